// File: rtl/m_console_tx_sink.sv
// Console TX sink: captures MMU writes to TX_ADDR into a byte FIFO and
// serializes them on w_txd as 8N1 frames, LSB first.
//
// state   | meaning
// S_IDLE  | line high, waiting for a FIFO byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module m_console_tx_sink #(
   parameter logic [31:0] TX_ADDR      = 32'h4000_0000,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [31:0]                   w_mem_paddr,
   input  logic                          w_mem_we,
   input  logic [31:0]                   w_mem_wdata,
   output logic                          w_tx_ready,
   output logic                          w_txd,
   output logic                          w_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   w_fifo_count,
   output logic                          w_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_q, bit_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            txd_q, txd_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic            addr_hit, push, pop, tmr_done;
   logic            unused_wdata;

   assign unused_wdata = ^w_mem_wdata[31:8];

   assign addr_hit   = w_mem_we && (w_mem_paddr == TX_ADDR);
   assign w_tx_ready = (count_q != FULL);
   assign push       = addr_hit && w_tx_ready;
   assign pop        = (state_q == S_IDLE) && (count_q != '0);
   assign tmr_done   = (tmr_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      tmr_d    = tmr_q;
      txd_d    = txd_q;
      ovf_d    = ovf_q | (addr_hit & ~w_tx_ready);

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_START;
               shift_d = mem_q[rd_ptr_q];
               tmr_d   = TMR_RELOAD;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (tmr_done) begin
               state_d = S_DATA;
               bit_d   = '0;
               tmr_d   = TMR_RELOAD;
               txd_d   = shift_q[0];
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_DATA: begin
            if (tmr_done) begin
               tmr_d = TMR_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  // shift_q[0] is always the bit currently on the line
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STOP: begin
            if (tmr_done) begin
               state_d = S_IDLE;
               txd_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         shift_q  <= '0;
         bit_q    <= '0;
         tmr_q    <= '0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         tmr_q    <= tmr_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= w_mem_wdata[7:0];
   end

   assign w_txd        = txd_q;
   assign w_tx_busy    = busy_q;
   assign w_fifo_count = count_q;
   assign w_overflow   = ovf_q;
endmodule

// File: tb/tb_m_console_tx_sink.sv
// Directed bench for m_console_tx_sink: serial frames are decoded by a
// line monitor and compared against bytes queued when writes are driven.
module tb_m_console_tx_sink;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 16;
   localparam logic [31:0] TXA   = 32'h4000_0000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] paddr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        ready, txd, busy, ovf;
   logic [4:0]  fcount;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   logic [7:0] sb [$];

   int         m_t = 0;
   bit         m_act = 0;
   logic [7:0] m_byte = '0;
   int         m_start = 0;
   int         m_prev_start = 0;

   logic [39:0] wave_obs, wave_exp;
   logic [7:0]  b55;
   int          busy_cyc, lows, busy_seen;

   m_console_tx_sink #(
      .TX_ADDR(TXA), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
   ) dut (
      .CLK(CLK), .RST(RST),
      .w_mem_paddr(paddr), .w_mem_we(we), .w_mem_wdata(wdata),
      .w_tx_ready(ready), .w_txd(txd), .w_tx_busy(busy),
      .w_fifo_count(fcount), .w_overflow(ovf)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_wr(input logic [31:0] a, input logic [7:0] d, input bit acc);
      paddr = a;
      wdata = {24'h5A5A5A, d};
      we    = 1'b1;
      if (acc) sb.push_back(d);
   endtask

   task automatic clr_wr();
      we    = 1'b0;
      paddr = '0;
      wdata = '0;
   endtask

   task automatic wait_drain(input int budget, input string tag);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge CLK);
         if (sb.size() == 0 && busy === 1'b0 && fcount === 5'd0) done = 1;
      end
      check(tag, done, 1);
   endtask

   // Line monitor: decodes 8N1 frames at bit centres
   initial forever begin
      @(negedge CLK);
      if (RST) begin
         m_act = 0;
      end else if (!m_act) begin
         if (txd === 1'b0) begin
            m_act        = 1;
            m_t          = 0;
            m_prev_start = m_start;
            m_start      = cyc;
         end
      end else begin
         m_t++;
         if (m_t > CPB && m_t < 9*CPB && (m_t % CPB) == CPB/2)
            m_byte[m_t/CPB - 1] = txd;
         if (m_t == 9*CPB + CPB/2) begin
            check("stop_bit", txd, 1);
            check("frame_expected", sb.size() != 0, 1);
            if (sb.size() != 0) check("rx_byte", m_byte, sb.pop_front());
            m_act = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge CLK);
      check("rst_ready", ready, 1);
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fcount, 0);
      check("rst_ovf", ovf, 0);
      RST = 1'b0;

      // Single 0x55 frame: exact line waveform and busy length
      @(negedge CLK); set_wr(TXA, 8'h55, 1);
      @(negedge CLK); clr_wr();
      check("push_count", fcount, 1);
      check("txd_before_pop", txd, 1);
      b55 = 8'h55;
      for (int i = 0; i < 40; i++)
         wave_exp[i] = (i < 4) ? 1'b0 : (i < 36) ? b55[(i-4)/4] : 1'b1;
      busy_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         wave_obs[i] = txd;
         if (busy === 1'b1) busy_cyc++;
      end
      check("frame_55_wave", wave_obs, wave_exp);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (busy === 1'b1) busy_cyc++;
      end
      check("busy_len", busy_cyc, 40);
      check("idle_txd", txd, 1);

      // Non-matching address is ignored
      @(negedge CLK); set_wr(TXA + 32'd4, 8'hA5, 0);
      @(negedge CLK); clr_wr();
      lows = 0; busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (txd !== 1'b1) lows++;
         if (busy !== 1'b0) busy_seen++;
      end
      check("bad_addr_count", fcount, 0);
      check("bad_addr_txd_lows", lows, 0);
      check("bad_addr_busy", busy_seen, 0);
      check("bad_addr_ovf", ovf, 0);

      // Back-to-back frames
      @(negedge CLK); set_wr(TXA, 8'hA5, 1);
      @(negedge CLK); set_wr(TXA, 8'h3C, 1);
      @(negedge CLK); clr_wr();
      check("b2b_same_edge_count", fcount, 1);
      wait_drain(300, "drain_b2b");
      check("start_spacing", m_start - m_prev_start, 41);

      // Fill past full with writes every cycle; indices wrap 15->0
      for (int i = 0; i < 17; i++) begin
         @(negedge CLK);
         if (i == 2) check("push_pop_count", fcount, 1);
         set_wr(TXA, 8'h10 + 8'(i), 1);
      end
      @(negedge CLK);
      check("full_count", fcount, 16);
      check("full_ready", ready, 0);
      check("full_ovf_before", ovf, 0);
      set_wr(TXA, 8'hEE, 0);
      @(negedge CLK); clr_wr();
      check("drop_ovf", ovf, 1);
      check("drop_count", fcount, 16);
      wait_drain(17*42 + 60, "drain_overflow");
      check("ovf_sticky", ovf, 1);

      // Reset in the middle of the third of five queued frames
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         set_wr(TXA, 8'h61 + 8'(i), 1);
      end
      @(negedge CLK); clr_wr();
      repeat (95) @(negedge CLK);
      check("pre_rst_busy", busy, 1);
      RST = 1'b1;
      sb.delete();
      #1;
      check("midrst_txd", txd, 1);
      check("midrst_count", fcount, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_ready", ready, 1);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      lows = 0; busy_seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (txd !== 1'b1) lows++;
         if (busy !== 1'b0) busy_seen++;
      end
      check("post_rst_txd_lows", lows, 0);
      check("post_rst_busy", busy_seen, 0);

      @(negedge CLK); set_wr(TXA, 8'h81, 1);
      @(negedge CLK); clr_wr();
      wait_drain(200, "drain_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
